// File: rtl/fir_data_sequencer.sv
// =====================================================================
// fir_data_sequencer : sample intake, circular data buffer and (data,tap) pair streamer
// Rev 1.0
// =====================================================================
`default_nettype none

module fir_data_sequencer #(
  parameter int NTAP = 11,
  parameter int AW   = 12,
  parameter int DW   = 32
) (
  input  logic          CLK,
  input  logic          Resetn,
  input  logic          ap_start,
  output logic          ap_done,
  input  logic          ss_tvalid,
  input  logic [DW-1:0] ss_tdata,
  input  logic          ss_tlast,
  output logic          ss_tready,
  output logic [3:0]    data_WE,
  output logic          data_EN,
  output logic [DW-1:0] data_Di,
  output logic [AW-1:0] data_A,
  input  logic [DW-1:0] data_Do,
  output logic          tap_EN,
  output logic [AW-1:0] tap_A,
  input  logic [DW-1:0] tap_Do,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [DW-1:0] m_tap,
  output logic          m_first,
  output logic          m_last,
  output logic          m_eos
);

  localparam int PW = $clog2(NTAP);
  localparam logic [PW-1:0] LAST_K = PW'(NTAP - 1);
  localparam logic [PW-1:0] NTAP_P = PW'(NTAP);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_WAIT_IN = 3'd2,
    S_WRITE   = 3'd3,
    S_ISSUE   = 3'd4,
    S_LATCH   = 3'd5,
    S_OUT     = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] head;
  logic [PW-1:0] k;          // doubles as the clear-word counter while in S_CLEAR
  logic          last_flag;
  logic [DW-1:0] sample;
  logic [PW-1:0] rd_idx;

  function automatic logic [AW-1:0] to_addr(input logic [PW-1:0] idx);
    return {{(AW-PW-2){1'b0}}, idx, 2'b00};
  endfunction

  // Newest sample sits at head; tap k pairs with the sample k steps older.
  assign rd_idx = (head >= k) ? (head - k) : (head + NTAP_P - k);

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ss_tready = 1'b0;
    data_EN   = 1'b0;
    data_WE   = 4'h0;
    data_Di   = '0;
    data_A    = '0;
    tap_EN    = 1'b0;
    tap_A     = '0;
    case (state)
      S_IDLE: begin
        if (ap_start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = to_addr(k);
        if (k == LAST_K) state_nxt = S_WAIT_IN;
      end
      S_WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        data_EN   = 1'b1;
        data_WE   = 4'hF;
        data_A    = to_addr(head);
        data_Di   = sample;
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        data_EN   = 1'b1;
        data_A    = to_addr(rd_idx);
        tap_EN    = 1'b1;
        tap_A     = to_addr(k);
        state_nxt = S_LATCH;
      end
      S_LATCH: begin
        state_nxt = S_OUT;
      end
      S_OUT: begin
        if (m_ready) begin
          if (k != LAST_K)   state_nxt = S_ISSUE;
          else if (last_flag) state_nxt = S_IDLE;
          else               state_nxt = S_WAIT_IN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      head      <= '0;
      k         <= '0;
      last_flag <= 1'b0;
      sample    <= '0;
      ap_done   <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_tap     <= '0;
      m_first   <= 1'b0;
      m_last    <= 1'b0;
      m_eos     <= 1'b0;
    end else begin
      ap_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            head <= '0;
            k    <= '0;
          end
        end
        S_CLEAR: begin
          k <= (k == LAST_K) ? '0 : k + PW'(1);
        end
        S_WAIT_IN: begin
          if (ss_tvalid) begin
            sample    <= ss_tdata;
            last_flag <= ss_tlast;
          end
        end
        S_WRITE: begin
          k <= '0;
        end
        S_LATCH: begin
          m_data  <= data_Do;
          m_tap   <= tap_Do;
          m_first <= (k == '0);
          m_last  <= (k == LAST_K);
          m_eos   <= (k == LAST_K) && last_flag;
          m_valid <= 1'b1;
        end
        S_OUT: begin
          if (m_ready) begin
            // Drop the whole pair so nothing stale is visible between pairs or in IDLE.
            m_valid <= 1'b0;
            m_data  <= '0;
            m_tap   <= '0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
            m_eos   <= 1'b0;
            if (k != LAST_K) begin
              k <= k + PW'(1);
            end else begin
              k    <= '0;
              head <= (head == LAST_K) ? '0 : head + PW'(1);
              if (last_flag) begin
                ap_done   <= 1'b1;
                last_flag <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_data_sequencer.sv
// =====================================================================
// tb_fir_data_sequencer : table-driven + randomized check of fir_data_sequencer against a sample-history model
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_fir_data_sequencer;

  localparam int NTAP = 11;
  localparam int AW   = 12;
  localparam int DW   = 32;

  logic          CLK = 1'b0;
  logic          Resetn;
  logic          ap_start, ap_done;
  logic          ss_tvalid, ss_tlast, ss_tready;
  logic [DW-1:0] ss_tdata;
  logic [3:0]    data_WE;
  logic          data_EN, tap_EN;
  logic [DW-1:0] data_Di, data_Do, tap_Do;
  logic [AW-1:0] data_A, tap_A;
  logic          m_valid, m_ready, m_first, m_last, m_eos;
  logic [DW-1:0] m_data, m_tap;

  fir_data_sequencer #(.NTAP(NTAP), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .Resetn(Resetn), .ap_start(ap_start), .ap_done(ap_done),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di), .data_A(data_A), .data_Do(data_Do),
    .tap_EN(tap_EN), .tap_A(tap_A), .tap_Do(tap_Do),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_tap(m_tap),
    .m_first(m_first), .m_last(m_last), .m_eos(m_eos)
  );

  always #5 CLK = ~CLK;

  // BRAM models; read data is garbage whenever no read was issued the cycle before.
  logic [DW-1:0] data_mem [0:1023];
  logic [DW-1:0] tap_mem  [0:1023];
  logic          scramble;

  always @(posedge CLK) begin
    if (scramble) begin
      for (int i = 0; i < 16; i++) data_mem[i] <= $urandom | 32'h1;
    end else if (data_EN && data_WE != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (data_WE[b]) data_mem[data_A[11:2]][8*b +: 8] <= data_Di[8*b +: 8];
    end
    if (data_EN && data_WE == 4'h0) data_Do <= data_mem[data_A[11:2]];
    else                            data_Do <= $urandom;
    if (tap_EN) tap_Do <= tap_mem[tap_A[11:2]];
    else        tap_Do <= $urandom;
  end

  // Reference model: every sample accepted since ap_start, plus the taps.
  logic [DW-1:0] hist [$];
  logic [DW-1:0] mtap [NTAP];
  int            nsamp;
  int            n_vec = 0;
  int            n_err = 0;

  typedef struct {
    logic        start;
    logic        tvalid;
    logic        en;
    logic [3:0]  we;
    logic [11:0] a;
    logic [31:0] di;
    logic        tready;
    logic        mvalid;
  } vec_t;
  vec_t tbl [13];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, 64'({ap_done, ss_tready, data_WE, data_EN, data_A, tap_EN, tap_A,
                               m_valid, m_first, m_last, m_eos}), 64'd0);
    check({tag, "_di"}, 64'(data_Di), 64'd0);
    check({tag, "_mdata"}, 64'(m_data), 64'd0);
    check({tag, "_mtap"}, 64'(m_tap), 64'd0);
  endtask

  task automatic set_taps(input bit rnd);
    for (int i = 0; i < NTAP; i++) begin
      mtap[i]    = rnd ? $urandom : 32'(i + 1);
      tap_mem[i] = mtap[i];
    end
  endtask

  // Must be called with the DUT in IDLE.
  task automatic do_start();
    int writes, t;
    scramble = 1'b1; @(negedge CLK); scramble = 1'b0;
    hist.delete(); nsamp = 0;
    ap_start = 1'b1; @(negedge CLK); ap_start = 1'b0;
    writes = 0; t = 0;
    while (!ss_tready && t < 40) begin
      if (data_EN && data_WE == 4'hF && data_Di == '0 && data_A == 12'(writes * 4)) writes++;
      @(negedge CLK); t++;
    end
    check("clear_writes", 64'(writes), 64'(NTAP));
    check("clear_tready", 64'(ss_tready), 64'd1);
  endtask

  task automatic send_sample(input logic [31:0] d, input logic lst, input int stall_pair,
                             input int stall_len, input int abort_pair);
    int t, n, idx;
    logic [31:0] ed;
    logic [11:0] ia, ta;
    logic [2:0]  ef;
    bit          got;
    ss_tdata = d; ss_tlast = lst; ss_tvalid = 1'b1;
    t = 0;
    while (!ss_tready && t < 200) begin @(negedge CLK); t++; end
    check("in_tready", 64'(ss_tready), 64'd1);
    if (!ss_tready) begin ss_tvalid = 1'b0; return; end
    @(negedge CLK);
    ss_tvalid = 1'b0;
    n = nsamp; hist.push_back(d); nsamp++;
    check("write_a",  64'(data_A), 64'((n % NTAP) * 4));
    check("write_di", 64'(data_Di), 64'(d));
    check("write_we", 64'({data_EN, data_WE}), 64'h1F);
    for (int k = 0; k < NTAP; k++) begin
      got = 1'b0; t = 0; ia = '0; ta = '0;
      while (!m_valid && t < 20) begin
        if (tap_EN) begin ia = data_A; ta = tap_A; got = 1'b1; end
        @(negedge CLK); t++;
      end
      check($sformatf("s%0d_p%0d_valid", n, k), 64'(m_valid), 64'd1);
      if (!m_valid) return;
      idx = ((n % NTAP) - k + NTAP) % NTAP;
      ed  = (k <= n) ? hist[n-k] : 32'h0;
      ef  = {k == 0, k == NTAP - 1, lst && (k == NTAP - 1)};
      check($sformatf("s%0d_p%0d_data", n, k), 64'(m_data), 64'(ed));
      check($sformatf("s%0d_p%0d_tap", n, k), 64'(m_tap), 64'(mtap[k]));
      check($sformatf("s%0d_p%0d_flags", n, k), 64'({m_first, m_last, m_eos}), 64'(ef));
      check($sformatf("s%0d_p%0d_issue", n, k), 64'({got, ia, ta}), 64'({1'b1, 12'(idx * 4), 12'(k * 4)}));
      if (k == abort_pair) return;
      if (k == stall_pair) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge CLK);
          check($sformatf("stall%0d_hold", s), 64'({m_valid, m_data, m_tap}), 64'({1'b1, ed, mtap[k]}));
          check($sformatf("stall%0d_noread", s), 64'({data_EN, tap_EN}), 64'd0);
        end
      end
      m_ready = 1'b1; @(negedge CLK); m_ready = 1'b0;
      check($sformatf("s%0d_p%0d_drop", n, k), 64'(m_valid), 64'd0);
    end
    if (lst) begin
      check("done_pulse", 64'(ap_done), 64'd1);
      @(negedge CLK);
      check("done_clear", 64'(ap_done), 64'd0);
      check("idle_tready", 64'(ss_tready), 64'd0);
    end else begin
      check("done_quiet", 64'(ap_done), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time bound exceeded, vectors=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 4'hF, 12'h000, 32'h0, 1'b0, 1'b0};
    for (int i = 1; i < NTAP; i++)
      tbl[i] = '{(i == 5), 1'b0, 1'b1, 4'hF, 12'(i * 4), 32'h0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 1'b0};

    Resetn = 1'b0; ap_start = 1'b0; ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0;
    m_ready = 1'b0; scramble = 1'b1;
    for (int i = 0; i < 1024; i++) tap_mem[i] = '0;
    set_taps(1'b0);
    repeat (3) @(negedge CLK);
    scramble = 1'b0;
    check_zero("reset");
    Resetn = 1'b1;
    @(negedge CLK);
    check_zero("idle");

    // Clear sequence, table driven; ap_start mid-clear and in WAIT_IN must be ignored.
    hist.delete(); nsamp = 0;
    for (int i = 0; i < 13; i++) begin
      ap_start = tbl[i].start; ss_tvalid = tbl[i].tvalid;
      @(negedge CLK);
      check($sformatf("clr%0d_en_we", i), 64'({data_EN, data_WE}), 64'({tbl[i].en, tbl[i].we}));
      check($sformatf("clr%0d_a", i), 64'(data_A), 64'(tbl[i].a));
      check($sformatf("clr%0d_di", i), 64'(data_Di), 64'(tbl[i].di));
      check($sformatf("clr%0d_rdy_v", i), 64'({ss_tready, m_valid}), 64'({tbl[i].tready, tbl[i].mvalid}));
    end
    ap_start = 1'b0;

    // Single sample, backpressure on pair 4, then a tlast sample.
    send_sample(32'd5, 1'b0, -1, 0, -1);
    send_sample(32'hA5A5_0007, 1'b0, 4, 7, -1);
    send_sample(32'h0000_0042, 1'b1, -1, 0, -1);
    ss_tvalid = 1'b1; ss_tdata = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge CLK);
      check("idle_reject", 64'({ss_tready, data_EN, m_valid}), 64'd0);
    end
    ss_tvalid = 1'b0;

    // Wrap-around: 13 samples land with head wrapping back to 1.
    do_start();
    for (int i = 1; i <= 13; i++) send_sample(32'(i), 1'b0, -1, 0, -1);
    send_sample(32'd14, 1'b1, -1, 0, -1);

    // Randomized stream with random taps and random backpressure.
    set_taps(1'b1);
    do_start();
    for (int i = 0; i < 30; i++)
      send_sample($urandom, (i == 29), $urandom_range(0, NTAP - 1), $urandom_range(0, 4), -1);

    // Reset during OUT of pair 6, then a fresh start must show a cleared buffer.
    do_start();
    send_sample($urandom, 1'b0, -1, 0, 6);
    Resetn = 1'b0;
    #1;
    check_zero("abort_async");
    @(negedge CLK);
    check_zero("abort_held");
    Resetn = 1'b1;
    @(negedge CLK);
    check_zero("abort_idle");
    do_start();
    send_sample(32'd9, 1'b1, -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fir_data_sequencer.md
Name: fir_data_sequencer

Overview:
- Control stage directly upstream of the 11-word bram11_rn instances in the FIR datapath.
- Accepts input samples on an AXI-Stream-style slave port and keeps the last 11 samples in the data BRAM as a circular buffer.
- For each accepted sample it reads the 11 (data, tap) word pairs from the data BRAM and the tap BRAM, one pair at a time.
- It streams those pairs to the downstream MAC with a valid/ready handshake.

Parameters:
- NTAP, 11, number of taps and BRAM words (pointer range 0..NTAP-1).
- AW, 12, BRAM byte-address width; word index k maps to address k<<2.
- DW, 32, data and tap word width.

Ports:
- CLK  in  1  single clock.
- Resetn  in  1  asynchronous active-low reset.
- ap_start  in  1  start pulse; ignored unless in IDLE.
- ap_done  out  1  one-cycle pulse after the last pair of the tlast sample is consumed.
- ss_tvalid  in  1  input sample valid.
- ss_tdata  in  DW  input sample.
- ss_tlast  in  1  marks the final sample of the stream.
- ss_tready  out  1  sample accepted when ss_tvalid && ss_tready.
- data_WE  out  4  data BRAM byte write enable.
- data_EN  out  1  data BRAM enable.
- data_Di  out  DW  data BRAM write data.
- data_A  out  AW  data BRAM byte address.
- data_Do  in  DW  data BRAM read data.
- tap_EN  out  1  tap BRAM read enable (tap BRAM is read-only here).
- tap_A  out  AW  tap BRAM byte address.
- tap_Do  in  DW  tap BRAM read data.
- m_valid  out  1  pair valid.
- m_ready  in  1  downstream ready.
- m_data  out  DW  data word of the pair.
- m_tap  out  DW  tap word of the pair.
- m_first  out  1  pair k==0; MAC clears its accumulator.
- m_last  out  1  pair k==NTAP-1.
- m_eos  out  1  m_last of the tlast sample.

Behaviour:
- Reset values: all outputs 0, including all BRAM address, write-enable and enable outputs and the m_* registers.
- Reset internals: state IDLE, head=0, k=0, last_flag=0.
- Reset asserted mid-operation aborts immediately; no partial pair stays valid.
- BRAM timing: Do is valid in the cycle after an EN=1 cycle with WE=0.
  - The sequencer latches Do in that cycle.
  - It never relies on Do holding its value afterwards.
- IDLE:
  - Every output low.
  - ap_start=1 -> CLEAR with c=0, head=0.
- CLEAR: one word per cycle.
  - Drives data_EN=1, data_WE=4'hF, data_Di=0, data_A=c<<2.
  - After c==NTAP-1 (11 cycles) -> WAIT_IN.
- WAIT_IN:
  - ss_tready=1 for this state only.
  - On a handshake, capture ss_tdata and ss_tlast (into last_flag), then -> WRITE.
  - Without ss_tvalid, stay.
- WRITE: one cycle.
  - Drives data_EN=1, data_WE=4'hF, data_A=head<<2, data_Di=captured sample.
  - Sets k=0, then -> ISSUE.
- ISSUE: one cycle.
  - data_EN=1, data_WE=0, data_A=idx<<2, where idx=(head-k) mod NTAP, computed by wrap (head>=k ? head-k : head+NTAP-k).
  - tap_EN=1, tap_A=k<<2.
  - -> LATCH.
- LATCH:
  - Registers m_data<=data_Do and m_tap<=tap_Do.
  - Registers m_first=(k==0), m_last=(k==NTAP-1), m_eos=m_last&&last_flag.
  - Sets m_valid<=1, then -> OUT.
- OUT: all m_* outputs are held stable until m_ready.
  - On the m_valid&&m_ready cycle, m_valid<=0.
  - If k<NTAP-1: k<=k+1, -> ISSUE.
  - Else, last_flag=0: head<=(head==NTAP-1)?0:head+1, -> WAIT_IN.
  - Else, last_flag=1: head is advanced as above, ap_done<=1 for one cycle, -> IDLE.
- Timing consequences:
  - Minimum throughput is one pair per 3 cycles.
  - Per-sample minimum is 1+1+3*11 = 35 cycles, counted from the handshake cycle to the final m_ready.
- Write-then-read: the WRITE at head followed by the ISSUE of k=0 at head must return the new sample. The BRAM write is complete before the following read.
- ap_start outside IDLE: ignored.
- ss_tvalid outside WAIT_IN: not accepted (ss_tready=0).
- Address upper bits: always zero; data_A and tap_A never exceed (NTAP-1)<<2 = 12'h028.

Test Plan:
- Clear check: reset, ap_start. Expect 11 write cycles with data_WE=4'hF, Di=0, A=0x000..0x028 in order, then ss_tready=1.
- Single sample, taps 1..11, sample 5: expect 11 pairs.
  - m_data=5 only at k=0; all other m_data=0.
  - m_tap=1..11; m_first on pair 0, m_last on pair 10.
- Wrap-around: send samples 1..13.
  - Sample 13 lands at head=1.
  - Its pairs carry m_data=13,12,11,...,3 with data_A=0x004,0x000,0x028,...,0x008.
- Backpressure: hold m_ready=0 for 7 cycles on pair 4. m_valid, m_data and m_tap stay stable, and no BRAM read is issued.
- tlast: 3 samples, third with tlast. m_eos=1 only on pair 10 of sample 3, ap_done pulses once, and the FSM returns to IDLE. ss_tvalid afterwards sees ss_tready=0.
- Reset mid-stream: drop Resetn during OUT on pair 6. All outputs are 0 immediately. A new ap_start re-clears the buffer, and the first sample's pairs show zeros except k=0.
